// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding.
//   No ports.
package serial_subtractor_pkg;

  // 2'd3 is unused; the FSM treats it as illegal and returns to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Request/result bundle for serial_subtractor.
//   Data_in_start   : request, accepted only while the unit is idle
//   Data_in_A/B     : minuend / subtrahend, sampled on the accepting edge
//   Data_in_Borrow  : borrow-in, sampled on the accepting edge
//   Data_out_Diff   : result register, updated only at completion
//   Data_out_Borrow : final borrow-out (1 = A < B + Borrow_in)
//   Data_out_busy   : high while the operation is shifting
//   Data_out_done   : one-cycle completion pulse
//   master drives the request side, slave (the subtractor) drives the results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Data_in_start;
  logic [WIDTH-1:0] Data_in_A;
  logic [WIDTH-1:0] Data_in_B;
  logic             Data_in_Borrow;
  logic [WIDTH-1:0] Data_out_Diff;
  logic             Data_out_Borrow;
  logic             Data_out_busy;
  logic             Data_out_done;

  modport master (
    output Data_in_start, Data_in_A, Data_in_B, Data_in_Borrow,
    input  Data_out_Diff, Data_out_Borrow, Data_out_busy, Data_out_done
  );

  modport slave (
    input  Data_in_start, Data_in_A, Data_in_B, Data_in_Borrow,
    output Data_out_Diff, Data_out_Borrow, Data_out_busy, Data_out_done
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// serial_subtractor_full_subtractor_cell
//   Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
//   i_a    : minuend bit
//   i_b    : subtrahend bit
//   i_bin  : borrow in
//   o_d    : difference bit
//   o_bout : borrow out
module serial_subtractor_full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, Diff = A - B - Borrow_in, one bit per clock, LSB first.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; discards any operation in flight
//   bus : serial_subtractor_if slave (request operands in, result/status out)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 difference bits need storing; the newest bit comes from the cell.
  logic [WIDTH-1:1] r_d_sh;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_d_sh_next;

  serial_subtractor_full_subtractor_cell u_cell (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  assign w_last      = (r_cnt == CntW'(WIDTH - 1));
  assign w_accept    = (r_state == StIdle) && bus.Data_in_start;
  assign w_d_sh_next = {w_d, r_d_sh};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.Data_in_start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: operand load, bit-serial shift, result capture at the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_br     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a_sh <= bus.Data_in_A;
      r_b_sh <= bus.Data_in_B;
      r_br   <= bus.Data_in_Borrow;
    end else if (r_state == StShift) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_d_sh <= w_d_sh_next[WIDTH-1:1];
      r_br   <= w_bo;
      if (w_last) begin
        r_diff   <= w_d_sh_next;
        r_borrow <= w_bo;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  // Outputs: decoded from registered state only
  always_comb begin
    bus.Data_out_Diff   = r_diff;
    bus.Data_out_Borrow = r_borrow;
    bus.Data_out_busy   = (r_state == StShift);
    bus.Data_out_done   = (r_state == StDone);
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(2)) if2 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Operand pattern for the held-start test.
  function automatic logic [7:0] pat_a(input int c);
    return 8'((c * 37 + 11) & 255);
  endfunction
  function automatic logic [7:0] pat_b(input int c);
    return 8'((c * 23 + 5) & 255);
  endfunction
  function automatic logic pat_bin(input int c);
    return (c % 3) == 0;
  endfunction

  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb);
    int k;
    if8.Data_in_A      = a;
    if8.Data_in_B      = b;
    if8.Data_in_Borrow = bin;
    if8.Data_in_start  = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!if8.Data_out_busy && k < 4);
    if8.Data_in_start  = 1'b0;
    // Scramble operands: only the accepting edge may matter.
    if8.Data_in_A      = ~a;
    if8.Data_in_B      = ~b;
    if8.Data_in_Borrow = ~bin;
    check({tag, "_accept"}, 32'(if8.Data_out_busy), 32'd1);
    k = 0;
    while (!if8.Data_out_done && k < 16) begin
      tick();
      k++;
    end
    check({tag, "_done"}, 32'(if8.Data_out_done), 32'd1);
    check({tag, "_diff"}, 32'(if8.Data_out_Diff), 32'(ed));
    check({tag, "_borrow"}, 32'(if8.Data_out_Borrow), 32'(eb));
  endtask

  task automatic run_op2(input int a, input int b, input int bin);
    int k;
    logic [1:0] ed;
    logic       eb;
    ed = 2'((a - b - bin) & 3);
    eb = (a < b + bin);
    if2.Data_in_A      = 2'(a);
    if2.Data_in_B      = 2'(b);
    if2.Data_in_Borrow = 1'(bin);
    if2.Data_in_start  = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!if2.Data_out_busy && k < 4);
    if2.Data_in_start = 1'b0;
    k = 0;
    while (!if2.Data_out_done && k < 8) begin
      tick();
      k++;
    end
    check($sformatf("w2_done_%0d_%0d_%0d", a, b, bin), 32'(if2.Data_out_done), 32'd1);
    check($sformatf("w2_diff_%0d_%0d_%0d", a, b, bin), 32'(if2.Data_out_Diff), 32'(ed));
    check($sformatf("w2_bo_%0d_%0d_%0d", a, b, bin), 32'(if2.Data_out_Borrow), 32'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    if8.Data_in_start = 1'b0; if8.Data_in_A = '0; if8.Data_in_B = '0; if8.Data_in_Borrow = 1'b0;
    if2.Data_in_start = 1'b0; if2.Data_in_A = '0; if2.Data_in_B = '0; if2.Data_in_Borrow = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_diff", 32'(if8.Data_out_Diff), 32'h0);
    check("rst_borrow", 32'(if8.Data_out_Borrow), 32'h0);
    check("rst_busy", 32'(if8.Data_out_busy), 32'h0);
    check("rst_done", 32'(if8.Data_out_done), 32'h0);
    check("rst_w2_diff", 32'(if2.Data_out_Diff), 32'h0);
    rst = 1'b0;
    tick();

    // 0x5A - 0x3C: busy for 8 cycles, done in the 9th, Diff=0x1E
    if8.Data_in_A = 8'h5A; if8.Data_in_B = 8'h3C; if8.Data_in_Borrow = 1'b0;
    if8.Data_in_start = 1'b1;
    tick();
    if8.Data_in_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_busy_%0d", i), 32'(if8.Data_out_busy), 32'd1);
      check($sformatf("t1_nodone_%0d", i), 32'(if8.Data_out_done), 32'd0);
      tick();
    end
    check("t1_done", 32'(if8.Data_out_done), 32'd1);
    check("t1_busy_low", 32'(if8.Data_out_busy), 32'd0);
    check("t1_diff", 32'(if8.Data_out_Diff), 32'h1E);
    check("t1_borrow", 32'(if8.Data_out_Borrow), 32'd0);
    tick();
    check("t1_done_pulse", 32'(if8.Data_out_done), 32'd0);
    check("t1_diff_hold", 32'(if8.Data_out_Diff), 32'h1E);

    // Wrap-around and borrow-in boundaries
    run_op8("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    tick();
    run_op8("t2b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    run_op8("t2c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();

    // Start held high with operands changing every cycle: accepts at c=0,10,20.
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if8.Data_in_A      = pat_a(c);
      if8.Data_in_B      = pat_b(c);
      if8.Data_in_Borrow = pat_bin(c);
      if8.Data_in_start  = 1'b1;
      tick();
      if (c % 10 == 8) begin
        done_cnt++;
        check($sformatf("t3_done_%0d", c), 32'(if8.Data_out_done), 32'd1);
        check($sformatf("t3_diff_%0d", c), 32'(if8.Data_out_Diff),
              32'(8'(pat_a(c - 8) - pat_b(c - 8) - 8'(pat_bin(c - 8)))));
        check($sformatf("t3_bo_%0d", c), 32'(if8.Data_out_Borrow),
              32'(int'(pat_a(c - 8)) < int'(pat_b(c - 8)) + int'(pat_bin(c - 8))));
      end else begin
        check($sformatf("t3_nodone_%0d", c), 32'(if8.Data_out_done), 32'd0);
      end
    end
    if8.Data_in_start = 1'b0;
    check("t3_done_count", 32'(done_cnt), 32'd3);
    // Last accepted operands (c=20): 0xEF - 0xD1 = 0x1E
    check("t3_last_diff", 32'(if8.Data_out_Diff), 32'h1E);
    tick();

    // Reset in the 4th SHIFT cycle
    if8.Data_in_A = 8'h55; if8.Data_in_B = 8'h11; if8.Data_in_Borrow = 1'b0;
    if8.Data_in_start = 1'b1;
    tick();
    if8.Data_in_start = 1'b0;
    tick();
    tick();
    tick();
    check("t4_busy_pre", 32'(if8.Data_out_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_diff", 32'(if8.Data_out_Diff), 32'h0);
    check("t4_rst_borrow", 32'(if8.Data_out_Borrow), 32'h0);
    check("t4_rst_busy", 32'(if8.Data_out_busy), 32'h0);
    check("t4_rst_done", 32'(if8.Data_out_done), 32'h0);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.Data_out_done || if8.Data_out_busy) done_cnt++;
    end
    check("t4_no_done_after_rst", 32'(done_cnt), 32'd0);
    run_op8("t4_after", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    tick();

    // New operands without start: result must hold
    for (int i = 0; i < 20; i++) begin
      if8.Data_in_A      = 8'(i * 29 + 7);
      if8.Data_in_B      = 8'(i * 13 + 200);
      if8.Data_in_Borrow = i[0];
      tick();
      check($sformatf("t5_hold_diff_%0d", i), 32'(if8.Data_out_Diff), 32'h0F);
      check($sformatf("t5_hold_bo_%0d", i), 32'(if8.Data_out_Borrow), 32'd0);
    end

    // WIDTH=2 exhaustive, back-to-back
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          run_op2(a, b, bin);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
